// File: rtl/multicycle_control_unit.sv
// Main control FSM of the multicycle RV32I core.
// Sequences fetch, decode, execute, memory and writeback from the IR opcode.
// It drives the ALU_Control inputs (ALU_CO_o, is_immediate_o) and every datapath
// mux select and enable. Fetch and data accesses stall on mem_ready_i.
//
// Ports:
//   clk, rst         - clock; asynchronous active-high reset (state -> FETCH)
//   opcode_i         - instr[6:0]; sampled only in DECODE and MEMADR
//   mem_ready_i      - memory completes the current access this cycle
//   pc_write_o       - unconditional PC load
//   pc_write_cond_o  - PC load gated by branch-taken
//   pc_source_o      - PC source: 0 = ALU result, 1 = ALUOut
//   ir_write_o       - IR / oldPC load
//   mem_read_o       - memory read request
//   mem_write_o      - memory write request
//   lorD_o           - address select: 0 = PC, 1 = ALUOut
//   reg_write_o      - register-file write enable
//   memto_reg_o      - rd source: 00 = ALUOut, 01 = MDR, 10 = PC
//   alu_src_a_o      - 00 = PC, 01 = oldPC, 10 = rs1, 11 = zero
//   alu_src_b_o      - 00 = rs2, 01 = 4, 10 = imm
//   ALU_CO_o         - 00 = add, 01 = branch, 10 = ALU op
//   is_immediate_o   - set only in EXEC_I
//   retire_o         - pulse in the final state of each legal instruction
//   illegal_o        - unknown opcode seen in DECODE
//   state_o          - current state (debug)
module multicycle_control_unit #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opcode_i,
  input  logic               mem_ready_i,
  output logic               pc_write_o,
  output logic               pc_write_cond_o,
  output logic               pc_source_o,
  output logic               ir_write_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               lorD_o,
  output logic               reg_write_o,
  output logic [1:0]         memto_reg_o,
  output logic [1:0]         alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic [1:0]         ALU_CO_o,
  output logic               is_immediate_o,
  output logic               retire_o,
  output logic               illegal_o,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  // Encoding is visible on state_o, so enumerator order is significant.
  typedef enum logic [STATE_W-1:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StBranch,
    StJal,
    StJalr,
    StLui,
    StAuipc
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    pc_source_o     = 1'b0;
    ir_write_o      = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    lorD_o          = 1'b0;
    reg_write_o     = 1'b0;
    memto_reg_o     = 2'b00;
    alu_src_a_o     = 2'b00;
    alu_src_b_o     = 2'b00;
    ALU_CO_o        = 2'b00;
    is_immediate_o  = 1'b0;
    retire_o        = 1'b0;
    illegal_o       = 1'b0;

    unique case (state_q)
      StFetch: begin
        // PC + 4 is computed every cycle; PC and IR load only when the fetch lands.
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
        if (mem_ready_i) state_d = StDecode;
      end
      StDecode: begin
        // Branch target oldPC + imm lands in ALUOut for BRANCH to use.
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        unique case (opcode_i)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalr;
          OpLui:           state_d = StLui;
          OpAuipc:         state_d = StAuipc;
          default: begin
            state_d   = StFetch;
            illegal_o = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b10;
        state_d     = (opcode_i == OpStore) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        mem_read_o = 1'b1;
        lorD_o     = 1'b1;
        if (mem_ready_i) state_d = StMemWb;
      end
      StMemWb: begin
        reg_write_o = 1'b1;
        memto_reg_o = 2'b01;
        retire_o    = 1'b1;
        state_d     = StFetch;
      end
      StMemWrite: begin
        mem_write_o = 1'b1;
        lorD_o      = 1'b1;
        retire_o    = mem_ready_i;
        if (mem_ready_i) state_d = StFetch;
      end
      StExecR: begin
        alu_src_a_o = 2'b10;
        ALU_CO_o    = 2'b10;
        state_d     = StAluWb;
      end
      StExecI: begin
        alu_src_a_o    = 2'b10;
        alu_src_b_o    = 2'b10;
        ALU_CO_o       = 2'b10;
        is_immediate_o = 1'b1;
        state_d        = StAluWb;
      end
      StAluWb: begin
        reg_write_o = 1'b1;
        retire_o    = 1'b1;
        state_d     = StFetch;
      end
      StBranch: begin
        alu_src_a_o     = 2'b10;
        ALU_CO_o        = 2'b01;
        pc_write_cond_o = 1'b1;
        pc_source_o     = 1'b1;
        retire_o        = 1'b1;
        state_d         = StFetch;
      end
      StJal, StJalr: begin
        // Target computed this cycle while rd captures the already-incremented PC.
        alu_src_a_o = (state_q == StJalr) ? 2'b10 : 2'b01;
        alu_src_b_o = 2'b10;
        pc_write_o  = 1'b1;
        reg_write_o = 1'b1;
        memto_reg_o = 2'b10;
        retire_o    = 1'b1;
        state_d     = StFetch;
      end
      StLui: begin
        alu_src_a_o = 2'b11;
        alu_src_b_o = 2'b10;
        state_d     = StAluWb;
      end
      StAuipc: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        state_d     = StAluWb;
      end
      default: begin
        // Unreachable encodings: all outputs stay at 0 and we recover to FETCH.
        state_d = StFetch;
      end
    endcase
  end

  assign state_o = state_q;

endmodule
